// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped data cache.
// Used by dcache_ctrl (FSM + memory interface) and dcache_store (arrays).
package dcache_pkg;

  localparam int OFFSET_W = 3;   // byte offset inside a 64-bit word
  localparam int DATA_W   = 64;  // cache word width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WTHRU  = 2'd2
  } state_t;

  // Number of index bits for a given line count.
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag bits are whatever is left above index and offset.
  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - $clog2(lines) - OFFSET_W;
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Valid/tag/data storage of the cache: one combinational read port and one
// write port. Only the valid bits are reset; a write always marks its line valid.
module dcache_store #(
  parameter int LINES  = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 57,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Valid bits: cleared asynchronously, set by any line write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Optional feature: define DCACHE_STATS_EN to add hit_cnt/miss_cnt outputs.
//
// Memory handshake: mem_req is the valid; mem_we/mem_addr/mem_wdata are
// stable while mem_req is high; the transfer completes on the cycle mem_ack
// is high (mem_ack acts as ready, a one-cycle pulse), and mem_req drops on
// that same clock edge. mem_ack outside REFILL/WTHRU is ignored.
module dcache_ctrl #(
  parameter int LINES  = 16,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  import dcache_pkg::*;

  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES);

  state_t              state_q, state_d;
  logic                done_q;
  logic [IDX_W-1:0]    addr_idx;
  logic [TAG_W-1:0]    addr_tag;
  logic [OFFSET_W-1:0] unused_offset;
  logic                line_valid;
  logic [TAG_W-1:0]    line_tag;
  logic [DATA_W-1:0]   line_data;
  logic                hit;
  logic                start_rd, start_wr;
  logic                st_we;
  logic [DATA_W-1:0]   st_data;

  assign addr_idx      = cpu_addr[OFFSET_W +: IDX_W];
  assign addr_tag      = cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_offset = cpu_addr[OFFSET_W-1:0];  // always zero for word accesses

  dcache_store #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (addr_idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (st_we),
    .wr_idx   (addr_idx),
    .wr_tag   (addr_tag),
    .wr_data  (st_data)
  );

  assign hit = line_valid && (line_tag == addr_tag);

  // Load data is only driven on a zero-cycle IDLE hit, otherwise zero.
  assign cpu_rdata = (state_q == IDLE && cpu_rd && hit) ? line_data : '0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stall and array write control.
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    start_rd = 1'b0;
    start_wr = 1'b0;
    st_we    = 1'b0;
    st_data  = cpu_wdata;
    case (state_q)
      IDLE: begin
        if (cpu_rd && !hit) begin
          stall    = 1'b1;
          start_rd = 1'b1;
          state_d  = REFILL;
        end else if (cpu_wr && !done_q) begin
          // done_q absorbs the store still presented right after its write-through
          stall    = 1'b1;
          start_wr = 1'b1;
          state_d  = WTHRU;
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (mem_ack) begin
          st_we   = 1'b1;
          st_data = mem_rdata;
          state_d = IDLE;
        end
      end
      WTHRU: begin
        stall = 1'b1;
        if (mem_ack) begin
          st_we   = hit;  // update only a resident line; never allocate
          st_data = cpu_wdata;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Store-completion flag, high for exactly the cycle after a write-through ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == WTHRU) && mem_ack;
    end
  end

  // Memory interface registers: launched on leaving IDLE, dropped on ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start_rd || start_wr) begin
      mem_req  <= 1'b1;
      mem_we   <= start_wr;
      mem_addr <= {cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      if (start_wr) begin
        mem_wdata <= cpu_wdata;
      end
    end else if ((state_q == REFILL || state_q == WTHRU) && mem_ack) begin
      mem_req <= 1'b0;
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating hit/miss counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (state_q == IDLE && cpu_rd && !stall && hit_cnt != 32'hFFFF_FFFF) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (start_rd && miss_cnt != 32'hFFFF_FFFF) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized
// load/store traffic against a line-level model of the cache contents.
module tb_dcache_ctrl;

  logic        clk;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_ctrl #(.LINES(16), .ADDR_W(64), .DATA_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model state ----------------
  // Each line remembers the full word address it holds and its data.
  bit          m_valid [16];
  logic [63:0] m_addr  [16];
  logic [63:0] m_data  [16];
  int          m_hits, m_misses;

  // Cycle expectations published by the driver for the compare process.
  bit          chk_en;
  bit          exp_stall, exp_mem_req, exp_mem_we, exp_rd_valid;
  logic [63:0] exp_mem_addr, exp_mem_wdata, exp_rdata;

  int          n_cmp, n_err;
  int          obs_stall;
  logic [63:0] obs_rdata;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check64("stall", 64'(stall), 64'(exp_stall));
      check64("mem_req", 64'(mem_req), 64'(exp_mem_req));
      if (stall) obs_stall++;
      if (exp_mem_req) begin
        check64("mem_we", 64'(mem_we), 64'(exp_mem_we));
        check64("mem_addr", mem_addr, exp_mem_addr);
        if (exp_mem_we) check64("mem_wdata", mem_wdata, exp_mem_wdata);
      end
      if (exp_rd_valid) begin
        check64("cpu_rdata", cpu_rdata, exp_rdata);
        obs_rdata = cpu_rdata;
      end
`ifdef DCACHE_STATS_EN
      check64("hit_cnt", 64'(hit_cnt), 64'(m_hits));
      check64("miss_cnt", 64'(miss_cnt), 64'(m_misses));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    exp_stall    = 1'b0;
    exp_mem_req  = 1'b0;
    exp_mem_we   = 1'b0;
    exp_rd_valid = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Idle cycles; a stray mem_ack now and then must be ignored.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      cpu_rd    = 1'b0;
      cpu_wr    = 1'b0;
      cpu_addr  = {$urandom, $urandom};
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = {$urandom, $urandom};
      clear_exp();
      next_cycle();
    end
    mem_ack = 1'b0;
  endtask

  // Load; a miss is served by memory after lat request cycles with fill.
  task automatic do_rd(input logic [63:0] addr, input int lat, input logic [63:0] fill,
                       output int stalls, output logic [63:0] rdata);
    int idx;
    bit h;
    idx = int'(addr[6:3]);
    h = m_valid[idx] && (m_addr[idx] == addr);
    obs_stall = 0;
    cpu_rd    = 1'b1;
    cpu_wr    = 1'b0;
    cpu_addr  = addr;
    cpu_wdata = {$urandom, $urandom};
    mem_ack   = 1'b0;
    if (!h) begin
      clear_exp();
      exp_stall = 1'b1;
      next_cycle();
      m_misses++;
      for (int c = 1; c <= lat; c++) begin
        exp_mem_req  = 1'b1;
        exp_mem_we   = 1'b0;
        exp_mem_addr = addr;
        mem_ack      = (c == lat);
        mem_rdata    = (c == lat) ? fill : {$urandom, $urandom};
        next_cycle();
      end
      mem_ack      = 1'b0;
      m_valid[idx] = 1'b1;
      m_addr[idx]  = addr;
      m_data[idx]  = fill;
    end
    clear_exp();
    exp_rd_valid = 1'b1;
    exp_rdata    = m_data[idx];
    next_cycle();
    m_hits++;
    cpu_rd       = 1'b0;
    exp_rd_valid = 1'b0;
    stalls = obs_stall;
    rdata  = obs_rdata;
  endtask

  // Store: write-through with lat request cycles, then one absorbed cycle.
  task automatic do_wr(input logic [63:0] addr, input logic [63:0] data, input int lat,
                       output int stalls);
    int idx;
    idx = int'(addr[6:3]);
    obs_stall = 0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
    mem_ack   = 1'b0;
    clear_exp();
    exp_stall = 1'b1;
    next_cycle();
    for (int c = 1; c <= lat; c++) begin
      exp_mem_req   = 1'b1;
      exp_mem_we    = 1'b1;
      exp_mem_addr  = addr;
      exp_mem_wdata = data;
      mem_ack       = (c == lat);
      mem_rdata     = {$urandom, $urandom};
      next_cycle();
    end
    mem_ack = 1'b0;
    if (m_valid[idx] && m_addr[idx] == addr) m_data[idx] = data;
    clear_exp();
    next_cycle();
    cpu_wr = 1'b0;
    stalls = obs_stall;
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = '0;
    a[6:3] = 4'($urandom_range(0, 15));
    a[8:7] = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) a[40] = 1'b1;
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int          st;
    int          lat;
    logic [63:0] rd_v, a, d;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    model_clear();
    clear_exp();
    chk_en = 1'b1;

    // Reset state
    next_cycle();
    check64("rst_mem_we", 64'(mem_we), 64'd0);
    check64("rst_mem_addr", mem_addr, 64'd0);
    check64("rst_mem_wdata", mem_wdata, 64'd0);
    check64("rst_cpu_rdata", cpu_rdata, 64'd0);
    next_cycle();
    reset = 1'b1;
    idle(2);

    // Read miss then hit
    do_rd(64'h40, 3, 64'hDEAD, st, rd_v);
    check64("t1_miss_stalls", 64'(st), 64'd4);
    check64("t1_fill_rdata", rd_v, 64'hDEAD);
    do_rd(64'h40, 1, 64'h0, st, rd_v);
    check64("t1_hit_stalls", 64'(st), 64'd0);
    check64("t1_hit_rdata", rd_v, 64'hDEAD);

    // Store to a resident line updates it
    do_wr(64'h40, 64'h1234, 2, st);
    check64("t2_wr_stalls", 64'(st), 64'd3);
    do_rd(64'h40, 1, 64'h0, st, rd_v);
    check64("t2_hit_stalls", 64'(st), 64'd0);
    check64("t2_hit_rdata", rd_v, 64'h1234);

    // Store to an invalid line does not allocate
    do_wr(64'h80, 64'h5555, 1, st);
    check64("t3_wr_stalls", 64'(st), 64'd2);
    do_rd(64'h80, 2, 64'hABCD, st, rd_v);
    check64("t3_rd_miss_stalls", 64'(st), 64'd3);
    check64("t3_rdata", rd_v, 64'hABCD);

    // Same index, different tag: aliasing lines evict each other
    do_rd(64'h008, 2, 64'h1111, st, rd_v);
    check64("t4_a_stalls", 64'(st), 64'd3);
    do_rd(64'h088, 2, 64'h2222, st, rd_v);
    check64("t4_b_stalls", 64'(st), 64'd3);
    check64("t4_b_rdata", rd_v, 64'h2222);
    do_rd(64'h008, 2, 64'h3333, st, rd_v);
    check64("t4_a_again_stalls", 64'(st), 64'd3);
    check64("t4_a_again_rdata", rd_v, 64'h3333);

    // Randomized traffic against the model
    for (int t = 0; t < 250; t++) begin
      a   = rand_addr();
      d   = {$urandom, $urandom};
      lat = $urandom_range(1, 5);
      if ($urandom_range(0, 2) == 0) do_wr(a, d, lat, st);
      else do_rd(a, lat, d, st, rd_v);
      idle($urandom_range(0, 2));
    end

    // Reset while a refill is outstanding
    do_rd(64'h40, 1, 64'h77, st, rd_v);  // make sure 0x40 is resident
    idle(1);
    cpu_rd   = 1'b1;
    cpu_addr = 64'h48;
    clear_exp();
    exp_stall = 1'b1;
    next_cycle();
    m_misses++;
    exp_mem_req  = 1'b1;
    exp_mem_we   = 1'b0;
    exp_mem_addr = 64'h48;
    next_cycle();
    cpu_rd = 1'b0;
    clear_exp();
    model_clear();
    reset = 1'b0;
    #1;
    check64("t5_mem_req_async", 64'(mem_req), 64'd0);
    mem_ack   = 1'b1;
    mem_rdata = 64'hBAD;
    next_cycle();
    reset = 1'b1;
    next_cycle();  // late ack seen in IDLE
    mem_ack = 1'b0;
    idle(1);
    do_rd(64'h40, 2, 64'h4040, st, rd_v);
    check64("t5_valid_cleared_stalls", 64'(st), 64'd3);
    check64("t5_rdata", rd_v, 64'h4040);
    do_rd(64'h48, 1, 64'h4848, st, rd_v);
    check64("t5_late_ack_ignored", 64'(st), 64'd2);
    do_rd(64'h40, 1, 64'h0, st, rd_v);
    check64("t6_hit_stalls", 64'(st), 64'd0);
`ifdef DCACHE_STATS_EN
    #1;
    check64("t6_miss_cnt", 64'(miss_cnt), 64'd2);
    check64("t6_hit_cnt", 64'(hit_cnt), 64'd3);
`endif
    idle(2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
